spi_slave_regs: RTL and testbench
=================================

Name: spi_slave_regs

Overview:
- Parametrised SPI mode-0 slave register bank between the Raspberry Pi and FPGA logic. Successor to the fixed 40-bit / 16-slot SPI slave.
- Frame format: 8-bit command header followed by a DATA_W-bit data word.
- Pi writes go to an output register bank, with a per-register write strobe.
- Pi reads are served from a flat input bus sampled at the end of the header.
- Adds async reset, configurable width/depth, same-frame (non-lagging) write visibility, out-of-range address handling and aborted-frame detection.

Parameters:
- DATA_W, 32, data word width in bits (8..64).
- ADDR_W, 4, address field width; ADDR_W <= 7.
- N_REGS, 16, number of implemented registers; N_REGS <= 2**ADDR_W.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SPI_CLK, SPI_CS and SPI_MOSI (>= 2).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- SPI_CLK, input, 1, SPI serial clock (CPOL=0, CPHA=0).
- SPI_CS, input, 1, chip select, active low.
- SPI_MOSI, input, 1, serial data from the Pi.
- SPI_MISO, output, 1, serial data to the Pi.
- rd_data, input, N_REGS*DATA_W, readable words; slot i = bits [i*DATA_W +: DATA_W].
- wr_data, output, N_REGS*DATA_W, written register bank, same packing as rd_data.
- wr_strobe, output, N_REGS, one-cycle pulse on the register written.
- frame_done, output, 1, one-cycle pulse when a complete frame ends.
- frame_err, output, 1, one-cycle pulse when a frame is aborted.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous, active high. It clears wr_data, wr_strobe, frame_done, frame_err, SPI_MISO, the shift register, the bit counter and the synchronisers, and puts the FSM in IDLE.
  - Reset mid-frame drops the frame; no write and no pulses occur.
- Synchronisation and edges:
  - All SPI inputs pass through SYNC_STAGES flip-flops.
  - Edges are detected against one further registered copy of sync SPI_CLK.
  - Rising edge: sample sync MOSI, shift it into the shift register MSB-first, increment the bit counter.
  - Falling edge: drive the next MISO bit.
  - clk must be >= 8x the SPI_CLK frequency.
- Frame:
  - FRAME_LEN = 8 + DATA_W.
  - Header bit7 = W (1 = write).
  - Header bits[ADDR_W-1:0] = address; the remaining header bits are ignored.
- FSM states:
  - IDLE: wait for sync CS low; clear counter and shift register, SPI_MISO=0; go to HEADER.
  - HEADER: count 8 rising edges. On the falling edge after bit 8, latch the read word: rd_data[addr] if addr < N_REGS, else all zeros. Drive its MSB on SPI_MISO. Go to DATA.
  - DATA: on each falling edge, shift the next read bit out MSB-first. After the rising edge that completes bit FRAME_LEN, go to DONE.
  - DONE: ignore further SPI_CLK edges. On sync CS high, return to IDLE.
- SPI_MISO is 0 during the header.
- Commit (single cycle, on entry to DONE):
  - Always pulse frame_done.
  - If W=1 and addr < N_REGS: load wr_data slot addr with the received word in that same cycle and pulse wr_strobe[addr].
  - If W=1 and addr >= N_REGS: no write, no strobe.
  - W=0: no write.
- Abort: sync CS high while in HEADER or DATA:
  - Pulse frame_err, go to IDLE, no write.
  - A frame of 0 bits (CS low then high with no SPI_CLK edges) is also an abort.
- Simultaneous events: if CS rises in the same cycle as the final rising edge is detected, the frame counts as complete (commit wins, no frame_err).
- wr_data holds its value between writes; unwritten slots stay 0.

Optional Feature:
- Macro: SPI_ERR_CNT_EN.
- Defined: adds output port err_cnt [7:0]. It is an 8-bit counter of aborted frames that saturates at 255 and is cleared only by reset. It increments in the same cycle frame_err pulses.
- Undefined: port and counter are absent; frame_err still exists.

Test Plan:
- Write: defaults, CS low, header 0x83, data 0xDEADBEEF, CS high -> wr_data slot 3 = 0xDEADBEEF, wr_strobe = 16'h0008 for one cycle, one frame_done; other slots unchanged.
- Read: rd_data slot 5 = 0x12345678, header 0x05 -> MISO returns 0x00 during the header then 0x12345678 MSB-first; no wr_strobe.
- Back-to-back writes: 0x81/0x00000001 then 0x81/0x00000002 -> wr_data slot 1 = 1 after frame 1 and 2 after frame 2 (no one-frame lag).
- Abort: CS high after 20 bits of a 0x82 write -> frame_err pulses, slot 2 unchanged, no frame_done; with SPI_ERR_CNT_EN, err_cnt = 1.
- Out of range: N_REGS=12, header 0x8E -> no strobe; header 0x0E -> 32 zero bits on MISO.
- Reset: assert reset after bit 30 of a write, then send a clean frame -> first frame lost, second commits normally, all outputs 0 during reset.

Source files
------------

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave register bank: 8-bit command header followed by a DATA_W-bit data word.
// Define SPI_ERR_CNT_EN to add the saturating aborted-frame counter output err_cnt.
module spi_slave_regs #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned N_REGS      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       SPI_CLK,
    input  logic                       SPI_CS,
    input  logic                       SPI_MOSI,
    output logic                       SPI_MISO,
    input  logic [N_REGS*DATA_W-1:0]   rd_data,
    output logic [N_REGS*DATA_W-1:0]   wr_data,
    output logic [N_REGS-1:0]          wr_strobe,
    output logic                       frame_done,
    output logic                       frame_err
`ifdef SPI_ERR_CNT_EN
    ,
    output logic [7:0]                 err_cnt
`endif
);

    localparam int unsigned FRAME_LEN = 8 + DATA_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {StIdle, StHeader, StData, StDone} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_q;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-1:0]      shreg;
    logic [DATA_W-1:0]      rd_sh;
    logic                   hdr_w;
    logic [ADDR_W-1:0]      hdr_addr;

    logic                   sclk_s, cs_s, mosi_s, rise, fall, last_rise, abort;
    logic [DATA_W-1:0]      rd_word, rx_word;

    // CS resets to its inactive level so the cycles after reset never look like a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_q;
    assign fall      = ~sclk_s & sclk_q;
    assign rx_word   = {shreg[DATA_W-2:0], mosi_s};
    assign last_rise = (state == StData) && rise && (cnt == CNT_W'(FRAME_LEN - 1));
    // A final edge coincident with CS rising still completes the frame
    assign abort     = cs_s && ((state == StHeader) || ((state == StData) && !last_rise));

    // Header sits in the low byte of the shift register when the read word is latched
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (shreg[ADDR_W-1:0] == ADDR_W'(i)) rd_word = rd_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            shreg      <= '0;
            rd_sh      <= '0;
            hdr_w      <= 1'b0;
            hdr_addr   <= '0;
            SPI_MISO   <= 1'b0;
            wr_data    <= '0;
            wr_strobe  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_strobe  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                StIdle: begin
                    SPI_MISO <= 1'b0;
                    if (!cs_s) begin
                        cnt   <= '0;
                        shreg <= '0;
                        state <= StHeader;
                    end
                end
                StHeader: begin
                    if (abort) begin
                        frame_err <= 1'b1;
                        state     <= StIdle;
                    end else if (rise) begin
                        shreg <= rx_word;
                        cnt   <= cnt + 1'b1;
                    end else if (fall && cnt == CNT_W'(8)) begin
                        hdr_w    <= shreg[7];
                        hdr_addr <= shreg[ADDR_W-1:0];
                        SPI_MISO <= rd_word[DATA_W-1];
                        rd_sh    <= {rd_word[DATA_W-2:0], 1'b0};
                        state    <= StData;
                    end
                end
                StData: begin
                    if (last_rise) begin
                        frame_done <= 1'b1;
                        state      <= StDone;
                        for (int i = 0; i < int'(N_REGS); i++) begin
                            if (hdr_w && hdr_addr == ADDR_W'(i)) begin
                                wr_data[i*DATA_W +: DATA_W] <= rx_word;
                                wr_strobe[i]                <= 1'b1;
                            end
                        end
                    end else if (abort) begin
                        frame_err <= 1'b1;
                        state     <= StIdle;
                    end else if (rise) begin
                        shreg <= rx_word;
                        cnt   <= cnt + 1'b1;
                    end else if (fall) begin
                        SPI_MISO <= rd_sh[DATA_W-1];
                        rd_sh    <= {rd_sh[DATA_W-2:0], 1'b0};
                    end
                end
                StDone: begin
                    if (cs_s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SPI_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (abort && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed vector table, reset-mid-frame sequence and random frames
// checked against an array-based model of the register bank.
module tb_spi_slave_regs;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 12;
    localparam int BW   = NR * DW;
    localparam int HALF = 80;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [BW-1:0] rd_data;
    logic [BW-1:0] wr_data;
    logic [NR-1:0] wr_strobe;
    logic          frame_done;
    logic          frame_err;
`ifdef SPI_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    always #5 clk = ~clk;

    spi_slave_regs #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .N_REGS     (NR),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SPI_CLK   (sclk),
        .SPI_CS    (cs),
        .SPI_MOSI  (mosi),
        .SPI_MISO  (miso),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .frame_done(frame_done),
        .frame_err (frame_err)
`ifdef SPI_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] rd_words  [NR];
    logic [DW-1:0] model_regs[NR];
    int            model_aborts = 0;

    int            done_seen = 0;
    int            err_seen  = 0;
    logic [NR-1:0] strobe_q[$];
    logic [BW-1:0] done_q[$];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NR; i++) rd_data[i*DW +: DW] = rd_words[i];
    end

    always @(negedge clk) begin
        if (frame_done) begin
            done_seen++;
            done_q.push_back(wr_data);
        end
        if (frame_err) err_seen++;
        if (wr_strobe != '0) strobe_q.push_back(wr_strobe);
    end

    typedef struct {
        logic [7:0]    hdr;
        logic [DW-1:0] data;
        int            nbits;
        logic [DW-1:0] exp_read;
        logic [NR-1:0] exp_strobe;
        logic          exp_done;
        logic          exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        for (int i = 0; i < NR; i++) b[i*DW +: DW] = model_regs[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        model_aborts = 0;
    endtask

    task automatic check_err_cnt();
`ifdef SPI_ERR_CNT_EN
        chk("err_cnt", BW'(err_cnt), BW'(model_aborts > 255 ? 255 : model_aborts));
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_data", wr_data, '0);
        chk("rst_pulses", BW'({wr_strobe, frame_done, frame_err, miso}), '0);
`ifdef SPI_ERR_CNT_EN
        chk("rst_err_cnt", BW'(err_cnt), '0);
`endif
    endtask

    // Drives one frame of nbits bits; rst_after >= 0 asserts reset after that bit index
    task automatic run_frame(input logic [7:0] hdr, input logic [DW-1:0] data, input int nbits,
                             input int rst_after, output logic [DW+7:0] rx);
        logic [DW+7:0] tx;
        tx = {hdr, data};
        rx = '0;
        cs = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[DW+7-i];
            #HALF;
            rx[DW+7-i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
            if (i == rst_after) begin
                reset = 1'b1;
                repeat (3) @(posedge clk);
                #2;
                check_reset_outputs();
                cs = 1'b1;
                repeat (4) @(posedge clk);
                #2;
                reset = 1'b0;
                model_reset();
                return;
            end
        end
        #HALF;
        cs = 1'b1;
        repeat (12) @(posedge clk);
        #2;
    endtask

    task automatic apply(input logic [7:0] hdr, input logic [DW-1:0] data, input int nbits,
                         input logic [DW-1:0] exp_read, input logic [NR-1:0] exp_strobe,
                         input logic exp_done, input logic exp_err);
        int            d0, e0, s0, n;
        logic [DW+7:0] rx;
        logic [NR-1:0] sv;
        logic [BW-1:0] snap;
        int            addr;
        d0   = done_seen;
        e0   = err_seen;
        s0   = strobe_q.size();
        addr = int'(hdr[AW-1:0]);
        run_frame(hdr, data, nbits, -1, rx);
        if (exp_done && hdr[7] && addr < NR) model_regs[addr] = data;
        if (exp_err) model_aborts++;
        chk("hdr_miso", BW'(rx[DW+7:DW]), '0);
        if (nbits == DW + 8) chk("rd_word", BW'(rx[DW-1:0]), BW'(exp_read));
        chk("done_pulses", BW'(done_seen - d0), BW'(exp_done));
        chk("err_pulses", BW'(err_seen - e0), BW'(exp_err));
        n  = strobe_q.size() - s0;
        sv = (n > 0) ? strobe_q[strobe_q.size()-1] : '0;
        chk("strobe_cycles", BW'(n), BW'(exp_strobe != '0 ? 1 : 0));
        chk("strobe_value", BW'(sv), BW'(exp_strobe));
        if (exp_strobe != '0 && done_seen > d0) begin
            snap = done_q[done_q.size()-1];
            chk("same_cycle_wr", BW'(snap[addr*DW +: DW]), BW'(data));
        end
        chk("wr_data", wr_data, model_bus());
        check_err_cnt();
    endtask

    initial begin
        logic [DW+7:0] rx;
        for (int i = 0; i < NR; i++) rd_words[i] = 32'hA500_0000 | DW'(i);
        rd_words[5] = 32'h1234_5678;
        model_reset();

        //          hdr    data           bits  exp_read       strobe   done  err
        tbl[0] = '{8'h83, 32'hDEAD_BEEF, 40,   32'hA500_0003, 12'h008, 1'b1, 1'b0};
        tbl[1] = '{8'h05, 32'h0BAD_F00D, 40,   32'h1234_5678, 12'h000, 1'b1, 1'b0};
        tbl[2] = '{8'h81, 32'h0000_0001, 40,   32'hA500_0001, 12'h002, 1'b1, 1'b0};
        tbl[3] = '{8'h81, 32'h0000_0002, 40,   32'hA500_0001, 12'h002, 1'b1, 1'b0};
        tbl[4] = '{8'h82, 32'hCAFE_F00D, 20,   32'h0000_0000, 12'h000, 1'b0, 1'b1};
        tbl[5] = '{8'h8E, 32'hFFFF_FFFF, 40,   32'h0000_0000, 12'h000, 1'b1, 1'b0};
        tbl[6] = '{8'h0E, 32'h0000_0000, 40,   32'h0000_0000, 12'h000, 1'b1, 1'b0};
        tbl[7] = '{8'h73, 32'h1111_2222, 40,   32'hA500_0003, 12'h000, 1'b1, 1'b0};
        tbl[8] = '{8'h8B, 32'h0F0F_0F0F, 0,    32'h0000_0000, 12'h000, 1'b0, 1'b1};
        tbl[9] = '{8'hFB, 32'h5A5A_A5A5, 40,   32'hA500_000B, 12'h800, 1'b1, 1'b0};

        repeat (4) @(posedge clk);
        #2;
        check_reset_outputs();
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("idle_no_pulses", BW'(done_seen + err_seen), '0);

        for (int v = 0; v < 10; v++) begin
            apply(tbl[v].hdr, tbl[v].data, tbl[v].nbits, tbl[v].exp_read, tbl[v].exp_strobe,
                  tbl[v].exp_done, tbl[v].exp_err);
        end

        // Reset after bit 30 of a write: frame lost, next frame commits normally
        begin
            int d0, e0, s0;
            d0 = done_seen;
            e0 = err_seen;
            s0 = strobe_q.size();
            run_frame(8'h84, 32'h5555_AAAA, 40, 29, rx);
            repeat (6) @(posedge clk);
            #2;
            chk("rst_frame_pulses", BW'(done_seen - d0 + err_seen - e0), '0);
            chk("rst_frame_strobe", BW'(strobe_q.size() - s0), '0);
            chk("rst_wr_data_after", wr_data, '0);
            apply(8'h84, 32'h55AA_55AA, 40, 32'hA500_0004, 12'h010, 1'b1, 1'b0);
        end

        for (int r = 0; r < 30; r++) begin
            logic [7:0]    hdr;
            logic [DW-1:0] data;
            int            nbits, addr;
            logic          full;
            hdr  = 8'($urandom);
            data = $urandom;
            rd_words[$urandom_range(NR-1)] = $urandom;
            nbits = ($urandom_range(4) == 0) ? int'($urandom_range(DW + 7)) : DW + 8;
            full  = (nbits == DW + 8);
            addr  = int'(hdr[AW-1:0]);
            apply(hdr, data, nbits,
                  (addr < NR) ? rd_words[addr] : '0,
                  (full && hdr[7] && addr < NR) ? NR'(1) << addr : '0,
                  full, !full);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
